// File: rtl/fas16_arbiter.sv
// Two-client round-robin arbiter/sequencer for one shared my_FAS_16 adder.
// A grant registers operands onto FAS_*, and the FAS_R result is captured one cycle later.

module fas16_slot #(
  parameter int WIDTH = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             cap,
  input  logic [WIDTH-1:0] fas_r,
  output logic             ack,
  output logic [WIDTH-1:0] r
);
  // ack follows cap by one edge, so it is high for the DONE cycle only
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      ack <= 1'b0;
      r   <= '0;
    end else begin
      ack <= cap;
      if (cap) r <= fas_r;
    end
  end
endmodule

module fas16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             SUB0,
  input  logic             SUB1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic             FAS_SUB,
  output logic [WIDTH-1:0] FAS_A,
  output logic [WIDTH-1:0] FAS_B,
  input  logic [WIDTH-1:0] FAS_R,
  output logic             BUSY
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef struct packed {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t                      state;
  logic                        last, owner, gnt;
  op_t    [1:0]                req_op;
  logic   [1:0]                cap, ack;
  logic   [1:0][WIDTH-1:0]     r;

  assign req_op[0] = '{sub: SUB0, a: A0, b: B0};
  assign req_op[1] = '{sub: SUB1, a: A1, b: B1};

  // Client 1 wins if it is alone, or on a tie when client 0 was served last
  assign gnt  = REQ1 & (~REQ0 | ~last);
  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      FAS_SUB <= 1'b0;
      FAS_A   <= '0;
      FAS_B   <= '0;
    end else begin
      case (state)
        IDLE: if (REQ0 | REQ1) begin
          FAS_SUB <= req_op[gnt].sub;
          FAS_A   <= req_op[gnt].a;
          FAS_B   <= req_op[gnt].b;
          last    <= gnt;
          owner   <= gnt;
          state   <= EXEC;
        end
        EXEC:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign cap[i] = (state == EXEC) && (owner == 1'(i));
    fas16_slot #(.WIDTH(WIDTH)) u_slot (
      .gclk   (CLK),
      .grst_n (RST_N),
      .cap    (cap[i]),
      .fas_r  (FAS_R),
      .ack    (ack[i]),
      .r      (r[i])
    );
  end

  assign ACK0 = ack[0];
  assign ACK1 = ack[1];
  assign R0   = r[0];
  assign R1   = r[1];
endmodule

// File: tb/tb_fas16_arbiter.sv
// Scoreboard bench for fas16_arbiter: stimulus pushes expected {client, result, cycle},
// a negedge monitor pops and compares on every ACK.
module tb_fas16_arbiter;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        REQ0 = 0, REQ1 = 0, SUB0 = 0, SUB1 = 0;
  logic [15:0] A0 = 0, A1 = 0, B0 = 0, B1 = 0;
  logic        ACK0, ACK1, FAS_SUB, BUSY;
  logic [15:0] R0, R1, FAS_A, FAS_B, FAS_R;

  // behavioural stand-in for the external my_FAS_16
  assign FAS_R = FAS_SUB ? FAS_A - FAS_B : FAS_A + FAS_B;

  fas16_arbiter #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1), .SUB0(SUB0), .SUB1(SUB1),
    .A0(A0), .A1(A1), .B0(B0), .B1(B1), .ACK0(ACK0), .ACK1(ACK1), .R0(R0), .R1(R1),
    .FAS_SUB(FAS_SUB), .FAS_A(FAS_A), .FAS_B(FAS_B), .FAS_R(FAS_R), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cl;
    logic [15:0] r;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0, cyc = 0;
  logic pa0 = 0, pa1 = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expect_ack(input int cl, input logic [15:0] r, input int at);
    sbq.push_back('{cl: cl, r: r, at: at});
  endtask

  // monitor
  always @(negedge CLK) begin
    exp_t e;
    int   cl;
    if (ACK0 || ACK1) begin
      chk("ack_exclusive", {31'b0, ACK0 & ACK1}, 0);
      chk("ack_one_cycle", {31'b0, (ACK0 & pa0) | (ACK1 & pa1)}, 0);
      cl = ACK1 ? 1 : 0;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack: client %0d at cycle %0d, none expected", cl, cyc);
      end else begin
        e = sbq.pop_front();
        chk("sb_client", cl, e.cl);
        chk("sb_result", cl ? R1 : R0, e.r);
        chk("sb_cycle", cyc, e.at);
      end
    end
    pa0 = ACK0;
    pa1 = ACK1;
  end

  task automatic drive(input int cl, input logic req, input logic s,
                       input logic [15:0] a, input logic [15:0] b);
    if (cl == 0) begin REQ0 = req; SUB0 = s; A0 = a; B0 = b; end
    else         begin REQ1 = req; SUB1 = s; A1 = a; B1 = b; end
  endtask

  // one isolated op, started at an IDLE negedge; ends at the next IDLE negedge
  task automatic single(input int cl, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r);
    drive(cl, 1, s, a, b);
    expect_ack(cl, r, cyc + 2);
    @(negedge CLK);
    chk("exec_fas_a", FAS_A, a);
    chk("exec_fas_b", FAS_B, b);
    chk("exec_fas_sub", FAS_SUB, s);
    chk("exec_busy", BUSY, 1);
    @(negedge CLK);
    if (cl == 0) REQ0 = 0; else REQ1 = 0;
    chk("done_busy", BUSY, 1);
    @(negedge CLK);
    chk("idle_busy", BUSY, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack0", ACK0, 0);
    chk("rst_ack1", ACK1, 0);
    chk("rst_r0", R0, 0);
    chk("rst_r1", R1, 0);
    chk("rst_fas_a", FAS_A, 0);
    chk("rst_fas_b", FAS_B, 0);
    chk("rst_fas_sub", FAS_SUB, 0);
    chk("rst_busy", BUSY, 0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    RST_N = 1;
    @(negedge CLK);

    single(0, 0, 16'd1, 16'd0, 16'd1);
    chk("r1_untouched", R1, 0);
    single(1, 1, 16'd1024, 16'd1023, 16'd1);
    chk("r0_held", R0, 1);

    // tie straight after reset: client 0 first
    RST_N = 0; #1;
    chk_reset_vals();
    @(negedge CLK); RST_N = 1;
    @(negedge CLK);
    c = cyc;
    drive(0, 1, 1, 16'd2, 16'd1);
    drive(1, 1, 0, 16'd1024, 16'd1);
    expect_ack(0, 16'd1, c + 2);
    expect_ack(1, 16'd1025, c + 5);
    @(negedge CLK);
    chk("tie1_fas", {FAS_SUB, FAS_A, FAS_B}, {1'b1, 16'd2, 16'd1});
    @(negedge CLK); REQ0 = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("tie2_fas", {FAS_SUB, FAS_A, FAS_B}, {1'b0, 16'd1024, 16'd1});
    @(negedge CLK); REQ1 = 0;
    @(negedge CLK);

    // fairness: both held for 12 ops
    c = cyc;
    drive(0, 1, 0, 16'd100, 16'd7);
    drive(1, 1, 1, 16'd50, 16'd8);
    for (int i = 0; i < 12; i++)
      expect_ack(i % 2, (i % 2) ? 16'd42 : 16'd107, c + 2 + 3 * i);
    repeat (35) @(negedge CLK);
    REQ0 = 0; REQ1 = 0;
    @(negedge CLK);

    // wrap-around
    single(0, 1, 16'h7FFF, 16'h8000, 16'hFFFF);
    single(1, 0, 16'hFFFF, 16'h0001, 16'h0000);
    chk("r0_untouched", R0, 16'hFFFF);

    // operands changed after grant must not matter
    drive(0, 1, 0, 16'd5, 16'd6);
    expect_ack(0, 16'd11, cyc + 2);
    @(negedge CLK);
    A0 = 16'hAAAA; B0 = 16'hAAAA; SUB0 = 1;
    @(negedge CLK); REQ0 = 0;
    @(negedge CLK);

    // reset during EXEC: no ACK, all cleared
    drive(0, 1, 0, 16'd3, 16'd4);
    @(negedge CLK);
    chk("pre_rst_busy", BUSY, 1);
    RST_N = 0; #1;
    chk_reset_vals();
    repeat (2) begin
      @(negedge CLK);
      chk("in_rst_r0", R0, 0);
      chk("in_rst_ack0", ACK0, 0);
    end
    drive(0, 1, 0, 16'd1, 16'd0);
    RST_N = 1;
    expect_ack(0, 16'd1, cyc + 2);
    repeat (2) @(negedge CLK);
    REQ0 = 0;
    repeat (3) @(negedge CLK);

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
